// File: rtl/hub75_bcm_scan_ctrl.sv
// rtl/hub75_bcm_scan_ctrl.sv - HUB75 scan/BCM sequencer; define HUB75_GHOST_BLANK_EN to move the row change ahead of the latch
module hub75_bcm_scan_ctrl #(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int BPC     = 4,
    parameter int GHOST_T = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  tick,
    input  logic                                  enable,
    input  logic [7:0]                            brightness,
    output logic                                  fb_rd_en,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  fb_addr,
    input  logic [6*BPC-1:0]                      fb_data,
    output logic                                  H75_R1,
    output logic                                  H75_G1,
    output logic                                  H75_B1,
    output logic                                  H75_R2,
    output logic                                  H75_G2,
    output logic                                  H75_B2,
    output logic                                  H75_A,
    output logic                                  H75_B,
    output logic                                  H75_C,
    output logic                                  H75_D,
    output logic                                  H75_E,
    output logic                                  H75_Clk,
    output logic                                  H75_Lat,
    output logic                                  H75_OE,
    output logic                                  frame_done
);

    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int PL_W    = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DW      = 8 + BPC;
    localparam int SH_W    = COL_W + 2;
    localparam int BC_W    = $clog2(GHOST_T + 2);
`ifdef HUB75_GHOST_BLANK_EN
    localparam int BLANK_LAST = GHOST_T;
`else
    localparam int BLANK_LAST = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_BLANK,
        S_LATCH,
        S_UNBLANK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SH_W-1:0]   sh_cnt;
    logic [ROW_W-1:0]  shift_row;
    logic [ROW_W-1:0]  row_addr;
    logic [PL_W-1:0]   plane;
    logic [DW-1:0]     disp_cnt;
    logic [DW-1:0]     disp_load;
    logic [BC_W-1:0]   blank_cnt;
    logic              lat_ph;
    logic [5:0]        col_q;
    logic [4:0]        row_pad;
    logic              shift_done;
    logic              blank_done;
    logic              ub_first;

    assign shift_done = (sh_cnt == SH_W'(2 * COLS));
    assign blank_done = (blank_cnt == BC_W'(BLANK_LAST));
    assign disp_load  = (DW'(brightness) + DW'(1)) << plane;
    // First UNBLANK tick is the one where OE is still high with a fresh on-time loaded.
    assign ub_first   = H75_OE && (disp_cnt != '0);

    assign row_pad = 5'(row_addr);
    assign {H75_E, H75_D, H75_C, H75_B, H75_A} = row_pad;
    assign {H75_B2, H75_G2, H75_R2, H75_B1, H75_G1, H75_R1} = col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                S_IDLE:    if (enable) state_nxt = S_SHIFT;
                S_SHIFT:   if (shift_done) state_nxt = S_WAIT;
                S_WAIT:    if (disp_cnt == '0) state_nxt = S_BLANK;
                S_BLANK:   if (blank_done) state_nxt = S_LATCH;
                S_LATCH:   if (lat_ph) state_nxt = S_UNBLANK;
                S_UNBLANK: begin
                    if (ub_first) begin
                        if (enable) state_nxt = S_SHIFT;
                    end else if (disp_cnt == '0) begin
                        state_nxt = S_IDLE;
                    end
                end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_rd_en   <= 1'b0;
            fb_addr    <= '0;
            frame_done <= 1'b0;
            H75_Clk    <= 1'b0;
            H75_Lat    <= 1'b0;
            H75_OE     <= 1'b1;
            col_q      <= '0;
            row_addr   <= '0;
            shift_row  <= '0;
            plane      <= '0;
            disp_cnt   <= '0;
            sh_cnt     <= '0;
            blank_cnt  <= '0;
            lat_ph     <= 1'b0;
        end else begin
            fb_rd_en   <= 1'b0;
            frame_done <= 1'b0;
            if (tick) begin
                // On-time counts down only while the panel is actually lit.
                if (!H75_OE && disp_cnt != '0) begin
                    disp_cnt <= disp_cnt - DW'(1);
                    if (disp_cnt == DW'(1)) H75_OE <= 1'b1;
                end
                case (state)
                    S_SHIFT: begin
                        if (shift_done) begin
                            H75_Clk <= 1'b0;
                            sh_cnt  <= '0;
                        end else if (!sh_cnt[0]) begin
                            fb_rd_en <= 1'b1;
                            fb_addr  <= {shift_row, sh_cnt[COL_W:1]};
                            H75_Clk  <= 1'b0;
                            sh_cnt   <= sh_cnt + SH_W'(1);
                        end else begin
                            for (int k = 0; k < 6; k++) begin
                                col_q[k] <= fb_data[k*BPC + int'(plane)];
                            end
                            H75_Clk <= 1'b1;
                            sh_cnt  <= sh_cnt + SH_W'(1);
                        end
                    end
                    S_BLANK: begin
                        H75_OE <= 1'b1;
`ifdef HUB75_GHOST_BLANK_EN
                        if (blank_cnt == '0) row_addr <= shift_row;
`endif
                        if (blank_done) begin
                            blank_cnt <= '0;
                        end else begin
                            blank_cnt <= blank_cnt + BC_W'(1);
                        end
                    end
                    S_LATCH: begin
                        if (!lat_ph) begin
                            H75_Lat  <= 1'b1;
                            lat_ph   <= 1'b1;
                            disp_cnt <= disp_load;
`ifndef HUB75_GHOST_BLANK_EN
                            row_addr <= shift_row;
`endif
                            frame_done <= (plane == PL_W'(BPC - 1)) &&
                                          (shift_row == ROW_W'(ROWS - 1));
                        end else begin
                            H75_Lat <= 1'b0;
                            lat_ph  <= 1'b0;
                        end
                    end
                    S_UNBLANK: begin
                        if (ub_first) begin
                            H75_OE <= 1'b0;
                            if (plane == PL_W'(BPC - 1)) begin
                                plane     <= '0;
                                shift_row <= shift_row + ROW_W'(1);
                            end else begin
                                plane <= plane + PL_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
